pipe_stage_reg: RTL and testbench

//  Generic pipeline stage register with valid/ready handshake, flush and optional skid slot.

---
 rtl/pipe_pkg.sv | 26 ++
 rtl/pipe_entry_reg.sv | 33 +++
 rtl/pipe_stage_reg.sv | 128 ++++++++++++
 tb/tb_pipe_stage_reg.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared encodings and defaults for pipe_stage_reg and pipe_entry_reg.
// Optional perf counters in the top are enabled by PIPE_STAGE_PERF_CNT_EN.
package pipe_pkg;

  localparam int DEF_CTRL_W = 8;
  localparam int DEF_DATA_W = 128;

  typedef logic [1:0]  state_t;
  typedef logic [31:0] perf_cnt_t;

  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_ONE   = 2'd1;
  localparam logic [1:0] ST_FULL  = 2'd2;

  // Occupancy is fully determined by the two entry valid bits.
  function automatic state_t state_of(input logic main_valid, input logic skid_valid);
    if (skid_valid)      return ST_FULL;
    else if (main_valid) return ST_ONE;
    else                 return ST_EMPTY;
  endfunction

  function automatic perf_cnt_t sat_inc(input perf_cnt_t cnt);
    return (cnt == 32'hFFFF_FFFF) ? cnt : cnt + 32'd1;
  endfunction

endpackage

// File: rtl/pipe_entry_reg.sv
// One held pipeline entry: valid + control + payload, with clear (bubble) and load.
// Clearing zeroes control but leaves payload stale.
module pipe_entry_reg #(
  parameter int CTRL_W = 8,
  parameter int DATA_W = 128
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              load,
  input  logic [CTRL_W-1:0] d_ctrl,
  input  logic [DATA_W-1:0] d_data,
  output logic              valid,
  output logic [CTRL_W-1:0] ctrl,
  output logic [DATA_W-1:0] data
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
      ctrl  <= '0;
      data  <= '0;
    end else if (clear) begin
      valid <= 1'b0;
      ctrl  <= '0;
    end else if (load) begin
      valid <= 1'b1;
      ctrl  <= d_ctrl;
      data  <= d_data;
    end
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with valid/ready handshake, flush and optional skid entry.
// Define PIPE_STAGE_PERF_CNT_EN to add the stall_cnt / flush_cnt outputs.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int CTRL_W = DEF_CTRL_W,
  parameter bit SKID   = 1'b1
) (
  input  logic              CLK,
  input  logic              Reset_n,
  input  logic              flush_in,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data
`ifdef PIPE_STAGE_PERF_CNT_EN
  ,
  output logic [31:0]       stall_cnt,
  output logic [31:0]       flush_cnt
`endif
);

  logic              main_valid;
  logic [CTRL_W-1:0] main_ctrl;
  logic [DATA_W-1:0] main_data;
  logic              skid_valid;
  logic [CTRL_W-1:0] skid_ctrl;
  logic [DATA_W-1:0] skid_data;

  logic              main_load, main_clear, main_sel_skid;
  logic              skid_load, skid_clear;
  logic              accept, emit;
  logic [CTRL_W-1:0] main_d_ctrl;
  logic [DATA_W-1:0] main_d_data;
  state_t            state;

  assign state     = state_of(main_valid, skid_valid);
  assign out_valid = (state != ST_EMPTY);
  assign out_ctrl  = main_ctrl;
  assign out_data  = main_data;

  assign accept = in_valid & in_ready;
  assign emit   = out_valid & out_ready;

  // Flush wins over everything; otherwise skid refills main first, then input.
  always_comb begin
    main_load     = 1'b0;
    main_clear    = 1'b0;
    main_sel_skid = 1'b0;
    skid_load     = 1'b0;
    skid_clear    = 1'b0;
    if (flush_in) begin
      main_clear = 1'b1;
      skid_clear = 1'b1;
    end else if (emit) begin
      if (skid_valid) begin
        main_load     = 1'b1;
        main_sel_skid = 1'b1;
        skid_clear    = 1'b1;
      end else if (accept) begin
        main_load = 1'b1;
      end else begin
        main_clear = 1'b1;
      end
    end else if (accept) begin
      if (main_valid) skid_load = 1'b1;
      else            main_load = 1'b1;
    end
  end

  assign main_d_ctrl = main_sel_skid ? skid_ctrl : in_ctrl;
  assign main_d_data = main_sel_skid ? skid_data : in_data;

  pipe_entry_reg #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) u_main (
    .clk    (CLK),
    .rst_n  (Reset_n),
    .clear  (main_clear),
    .load   (main_load),
    .d_ctrl (main_d_ctrl),
    .d_data (main_d_data),
    .valid  (main_valid),
    .ctrl   (main_ctrl),
    .data   (main_data)
  );

  generate
    if (SKID) begin : g_skid
      pipe_entry_reg #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) u_skid (
        .clk    (CLK),
        .rst_n  (Reset_n),
        .clear  (skid_clear),
        .load   (skid_load),
        .d_ctrl (in_ctrl),
        .d_data (in_data),
        .valid  (skid_valid),
        .ctrl   (skid_ctrl),
        .data   (skid_data)
      );
      // Straight from the skid flop: breaks the out_ready -> in_ready path.
      assign in_ready = ~skid_valid;
    end else begin : g_noskid
      logic unused_skid;
      assign unused_skid = skid_load ^ skid_clear;
      assign skid_valid  = 1'b0;
      assign skid_ctrl   = '0;
      assign skid_data   = '0;
      assign in_ready    = out_ready | ~out_valid;
    end
  endgenerate

`ifdef PIPE_STAGE_PERF_CNT_EN
  always_ff @(posedge CLK or negedge Reset_n) begin
    if (!Reset_n) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (out_valid && !out_ready)            stall_cnt <= sat_inc(stall_cnt);
      if (flush_in && (state != ST_EMPTY))    flush_cnt <= sat_inc(flush_cnt);
    end
  end
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg: SKID=1 and SKID=0 instances share stimulus,
// each checked against its own occupancy/ordering scoreboard queue.
module tb_pipe_stage_reg;

  localparam int DW = 16;
  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          flush_in;
  logic          in_valid;
  logic [CW-1:0] in_ctrl;
  logic [DW-1:0] in_data;
  logic          out_ready;

  logic          rdy1, vld1, rdy0, vld0;
  logic [CW-1:0] ctl1, ctl0;
  logic [DW-1:0] dat1, dat0;
`ifdef PIPE_STAGE_PERF_CNT_EN
  logic [31:0]   stall1, flush1, stall0, flush0;
`endif

  int checks = 0;
  int errors = 0;

  logic [CW+DW-1:0] q1[$];
  logic [CW+DW-1:0] q0[$];

  always #5 clk = ~clk;

  pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .SKID(1'b1)) u_skid (
    .CLK(clk), .Reset_n(rst_n), .flush_in(flush_in),
    .in_valid(in_valid), .in_ready(rdy1), .in_ctrl(in_ctrl), .in_data(in_data),
    .out_valid(vld1), .out_ready(out_ready), .out_ctrl(ctl1), .out_data(dat1)
`ifdef PIPE_STAGE_PERF_CNT_EN
    , .stall_cnt(stall1), .flush_cnt(flush1)
`endif
  );

  pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .SKID(1'b0)) u_noskid (
    .CLK(clk), .Reset_n(rst_n), .flush_in(flush_in),
    .in_valid(in_valid), .in_ready(rdy0), .in_ctrl(in_ctrl), .in_data(in_data),
    .out_valid(vld0), .out_ready(out_ready), .out_ctrl(ctl0), .out_data(dat0)
`ifdef PIPE_STAGE_PERF_CNT_EN
    , .stall_cnt(stall0), .flush_cnt(flush0)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: drive at negedge, check outputs before posedge, update models after it.
  task automatic cycle(input logic iv, input logic [CW-1:0] ic, input logic [DW-1:0] id,
                       input logic ordy, input logic fl);
    logic e_rdy1, e_rdy0, acc1, acc0, em1, em0;
    in_valid = iv; in_ctrl = ic; in_data = id; out_ready = ordy; flush_in = fl;
    #1;
    e_rdy1 = (q1.size() < 2);
    e_rdy0 = ordy || (q0.size() == 0);
    chk("skid.in_ready", 32'(rdy1), 32'(e_rdy1));
    chk("noskid.in_ready", 32'(rdy0), 32'(e_rdy0));
    chk("skid.out_valid", 32'(vld1), 32'(q1.size() != 0));
    chk("noskid.out_valid", 32'(vld0), 32'(q0.size() != 0));
    if (q1.size() != 0) begin
      chk("skid.out_ctrl", 32'(ctl1), 32'(q1[0][CW+DW-1:DW]));
      chk("skid.out_data", 32'(dat1), 32'(q1[0][DW-1:0]));
    end else chk("skid.out_ctrl_bubble", 32'(ctl1), 32'd0);
    if (q0.size() != 0) begin
      chk("noskid.out_ctrl", 32'(ctl0), 32'(q0[0][CW+DW-1:DW]));
      chk("noskid.out_data", 32'(dat0), 32'(q0[0][DW-1:0]));
    end else chk("noskid.out_ctrl_bubble", 32'(ctl0), 32'd0);
    $display("t=%0t iv=%0b ctrl=%0h data=%0h ordy=%0b fl=%0b | skid v=%0b d=%0h r=%0b | noskid v=%0b d=%0h r=%0b",
             $time, iv, ic, id, ordy, fl, vld1, dat1, rdy1, vld0, dat0, rdy0);
    acc1 = iv && e_rdy1;
    acc0 = iv && e_rdy0;
    em1  = (q1.size() != 0) && ordy;
    em0  = (q0.size() != 0) && ordy;
    @(posedge clk);
    if (fl) begin
      q1.delete();
      q0.delete();
    end else begin
      if (em1) void'(q1.pop_front());
      if (em0) void'(q0.pop_front());
      if (acc1) q1.push_back({ic, id});
      if (acc0) q0.push_back({ic, id});
    end
    @(negedge clk);
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, ".skid.out_valid"}, 32'(vld1), 32'd0);
    chk({tag, ".skid.out_ctrl"}, 32'(ctl1), 32'd0);
    chk({tag, ".skid.out_data"}, 32'(dat1), 32'd0);
    chk({tag, ".skid.in_ready"}, 32'(rdy1), 32'd1);
    chk({tag, ".noskid.out_valid"}, 32'(vld0), 32'd0);
    chk({tag, ".noskid.out_ctrl"}, 32'(ctl0), 32'd0);
`ifdef PIPE_STAGE_PERF_CNT_EN
    chk({tag, ".stall_cnt"}, stall1, 32'd0);
    chk({tag, ".flush_cnt"}, flush1, 32'd0);
`endif
  endtask

  // Async reset asserted mid-cycle, checked before any clock edge, released at negedge.
  task automatic do_reset(input string tag);
    in_valid = 1'b0; flush_in = 1'b0; out_ready = 1'b0;
    #2 rst_n = 1'b0;
    #1 check_reset_state(tag);
    q1.delete();
    q0.delete();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b1; flush_in = 1'b0; in_valid = 1'b0; in_ctrl = '0; in_data = '0; out_ready = 1'b0;
    @(negedge clk);
    do_reset("reset_init");

    // Stream: back-to-back, one-cycle latency, no gaps.
    cycle(1'b1, 8'h11, 16'd1, 1'b1, 1'b0);
    cycle(1'b1, 8'h12, 16'd2, 1'b1, 1'b0);
    cycle(1'b1, 8'h13, 16'd3, 1'b1, 1'b0);
    cycle(1'b0, 8'h00, 16'd0, 1'b1, 1'b0);
    cycle(1'b0, 8'h00, 16'd0, 1'b1, 1'b0);

    // Stall: skid takes 6 then closes; no-skid drops ready while holding 5.
    cycle(1'b1, 8'h25, 16'd5, 1'b1, 1'b0);
    cycle(1'b1, 8'h26, 16'd6, 1'b0, 1'b0);
    cycle(1'b1, 8'h27, 16'd7, 1'b0, 1'b0);
    cycle(1'b1, 8'h27, 16'd7, 1'b0, 1'b0);
    cycle(1'b0, 8'h00, 16'd0, 1'b1, 1'b0);
    cycle(1'b0, 8'h00, 16'd0, 1'b1, 1'b0);
    cycle(1'b0, 8'h00, 16'd0, 1'b1, 1'b0);

    // No-skid: stalled ONE, then simultaneous accept+emit.
    cycle(1'b1, 8'h39, 16'd9, 1'b1, 1'b0);
    cycle(1'b1, 8'h3A, 16'd10, 1'b0, 1'b0);
    cycle(1'b1, 8'h3A, 16'd10, 1'b1, 1'b0);
    cycle(1'b0, 8'h00, 16'd0, 1'b1, 1'b0);
    cycle(1'b0, 8'h00, 16'd0, 1'b1, 1'b0);

    // Flush while FULL with an input offered: nothing survives.
    cycle(1'b1, 8'hFF, 16'd20, 1'b0, 1'b0);
    cycle(1'b1, 8'hFF, 16'd21, 1'b0, 1'b0);
    cycle(1'b1, 8'hFF, 16'd22, 1'b1, 1'b1);
    cycle(1'b0, 8'h00, 16'd0, 1'b1, 1'b0);
    cycle(1'b1, 8'h01, 16'd23, 1'b1, 1'b0);
    cycle(1'b0, 8'h00, 16'd0, 1'b1, 1'b0);
    cycle(1'b0, 8'h00, 16'd0, 1'b1, 1'b0);

`ifdef PIPE_STAGE_PERF_CNT_EN
    do_reset("reset_perf");
    cycle(1'b1, 8'h44, 16'd30, 1'b1, 1'b0);
    cycle(1'b0, 8'h00, 16'd0, 1'b0, 1'b0);
    cycle(1'b0, 8'h00, 16'd0, 1'b0, 1'b0);
    cycle(1'b0, 8'h00, 16'd0, 1'b0, 1'b0);
    cycle(1'b0, 8'h00, 16'd0, 1'b1, 1'b1);
    cycle(1'b0, 8'h00, 16'd0, 1'b1, 1'b1);
    chk("skid.stall_cnt", stall1, 32'd3);
    chk("skid.flush_cnt", flush1, 32'd1);
    chk("noskid.stall_cnt", stall0, 32'd3);
    chk("noskid.flush_cnt", flush0, 32'd1);
`endif

    // Reset while FULL, then first post-reset entry flows normally.
    cycle(1'b1, 8'h50, 16'd40, 1'b0, 1'b0);
    cycle(1'b1, 8'h51, 16'd41, 1'b0, 1'b0);
    chk("pre_reset.skid.full", 32'(rdy1), 32'd0);
    do_reset("reset_mid");
    cycle(1'b1, 8'h52, 16'd42, 1'b1, 1'b0);
    cycle(1'b0, 8'h00, 16'd0, 1'b1, 1'b0);
    cycle(1'b0, 8'h00, 16'd0, 1'b1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
